rf_param_bypass: RTL and testbench

//   Parametrised multi-read-port register file with synchronous write and registered read.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_dump_fsm.sv | 80 ++++++++
 rtl/rf_param_bypass.sv | 91 +++++++++
 tb/tb_rf_param_bypass.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file and its dump engine.
package rf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } rf_state_e;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;

    // With a hard-wired zero register there is nothing worth dumping at index 0.
    function automatic int first_idx(input int zero_reg);
        return (zero_reg != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/rf_dump_fsm.sv
// Halt-triggered dump sequencer: hlt edge detect, IDLE/DUMP/DONE control and the beat index.
module rf_dump_fsm
    import rf_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hlt,
    input  logic              i_dump_ready,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_busy,
    output logic              o_dump_valid,
    output logic              o_dump_done
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(first_idx(ZERO_REG));
    localparam logic [ADDR_W-1:0] LAST  = '1;

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_hlt_q;
    logic              w_start;

    assign w_start = i_hlt && !r_hlt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_hlt_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_hlt_q <= i_hlt;
        end
    end

    // idx only moves on an accepted beat and stops at the last register instead of wrapping.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        o_dump_valid = 1'b0;
        o_dump_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = DUMP;
                    w_idx_nxt   = FIRST;
                end
            end
            DUMP: begin
                o_dump_valid = 1'b1;
                if (i_dump_ready) begin
                    if (r_idx == LAST) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                o_dump_done = 1'b1;
                if (!i_hlt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_idx  = r_idx;
    assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/rf_param_bypass.sv
// Multi-read-port register file with registered reads, write-to-read bypass and a
// valid/ready register dump started by a rising edge on hlt.
module rf_param_bypass
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     hlt,
    output logic                     busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] w_idx;
    logic              w_busy;
    logic              w_wr_eff;

    rf_dump_fsm #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_dump_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hlt        (hlt),
        .i_dump_ready (dump_ready),
        .o_idx        (w_idx),
        .o_busy       (w_busy),
        .o_dump_valid (dump_valid),
        .o_dump_done  (dump_done)
    );

    // Freezing writes while busy keeps the dumped image a consistent snapshot.
    assign w_wr_eff = wr_en && !w_busy && !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_eff) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] r_rd;

        assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];

        // Zero-register check wins over bypass so R0 can never leak write data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd <= '0;
            end else if (rd_en[i]) begin
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    r_rd <= '0;
                end else if ((BYPASS != 0) && w_wr_eff && (wr_addr == w_ra)) begin
                    r_rd <= wr_data;
                end else begin
                    r_rd <= r_mem[w_ra];
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = r_rd;
    end

    assign busy      = w_busy;
    assign dump_addr = w_idx;
    assign dump_data = r_mem[w_idx];

endmodule

// File: tb/tb_rf_param_bypass.sv
// Bench for rf_param_bypass: vector table for reads/writes/bypass plus dump and reset sequences.
module tb_rf_param_bypass;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] rd_data_b;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hlt;
    logic        busy, dump_valid, dump_ready, dump_done;
    logic [3:0]  dump_addr;
    logic [15:0] dump_data;
    logic        busy_b, dump_valid_b, dump_done_b;
    logic        dump_ready_b = 1'b1;
    logic [3:0]  dump_addr_b;
    logic [15:0] dump_data_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_param_bypass u_dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt), .busy(busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_done(dump_done)
    );

    rf_param_bypass #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt), .busy(busy_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready_b), .dump_addr(dump_addr_b),
        .dump_data(dump_data_b), .dump_done(dump_done_b)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  re;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e0b;
        logic [15:0] e1b;
    } vec_t;

    typedef struct {
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e0b;
        logic [15:0] e1b;
        string       tag;
    } rd_exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } beat_t;

    vec_t    vecs [11];
    rd_exp_t rd_q [$];
    beat_t   dump_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue what both instances must show one cycle later, then compare.
    task automatic apply_rd(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                            input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e0b, input logic [15:0] e1b, input string tag);
        rd_exp_t x;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = {ra1, ra0};
        x.e0 = e0; x.e1 = e1; x.e0b = e0b; x.e1b = e1b; x.tag = tag;
        rd_q.push_back(x);
        step();
        wr_en = 1'b0;
        rd_en = 2'b00;
        x = rd_q.pop_front();
        check({x.tag, "_p0"},   {16'h0, rd_data[15:0]},    {16'h0, x.e0});
        check({x.tag, "_p1"},   {16'h0, rd_data[31:16]},   {16'h0, x.e1});
        check({x.tag, "_b_p0"}, {16'h0, rd_data_b[15:0]},  {16'h0, x.e0b});
        check({x.tag, "_b_p1"}, {16'h0, rd_data_b[31:16]}, {16'h0, x.e1b});
    endtask

    initial begin
        int          beats;
        int          done_cyc;
        int          found;
        logic        done_seen;
        logic        hold_pending;
        logic [3:0]  hold_addr;
        logic [15:0] hold_data;
        beat_t       b;

        //            we   wa    wd        re     ra0   ra1   e0        e1        e0b       e1b
        vecs[0]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd2, 4'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 4'd5, 16'hBEEF, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 4'd7, 16'hAAAA, 2'b01, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[4]  = '{1'b1, 4'd7, 16'h1234, 2'b10, 4'd5, 4'd7, 16'hBEEF, 16'h1234, 16'hBEEF, 16'hAAAA};
        vecs[5]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd7, 4'd7, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vecs[6]  = '{1'b1, 4'd0, 16'hFFFF, 2'b00, 4'd0, 4'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 2'b11, 4'd0, 4'd5, 16'h0000, 16'hBEEF, 16'hFFFF, 16'hBEEF};
        vecs[8]  = '{1'b1, 4'd0, 16'h5555, 2'b01, 4'd0, 4'd5, 16'h0000, 16'hBEEF, 16'hFFFF, 16'hBEEF};
        vecs[9]  = '{1'b1, 4'd3, 16'h0033, 2'b11, 4'd3, 4'd0, 16'h0033, 16'h0000, 16'h0000, 16'h5555};
        vecs[10] = '{1'b0, 4'd5, 16'hDEAD, 2'b01, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h5555};

        rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; hlt = 1'b0; dump_ready = 1'b0;

        // Outputs while reset is held
        #12;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_dump_valid", {31'h0, dump_valid}, 32'h0);
        check("rst_dump_done", {31'h0, dump_done}, 32'h0);
        check("rst_dump_data", {16'h0, dump_data}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            apply_rd(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra0, vecs[i].ra1,
                     vecs[i].e0, vecs[i].e1, vecs[i].e0b, vecs[i].e1b, $sformatf("vec%0d", i));
        end

        // Load Rn = n*0x0101, then dump with a write on the start cycle and one while busy
        for (int n = 1; n < 16; n++) begin
            wr_en = 1'b1; wr_addr = 4'(n); wr_data = 16'(n * 16'h0101);
            step();
        end
        wr_en = 1'b0;
        for (int n = 1; n < 16; n++) begin
            b.addr = 4'(n);
            b.data = (n == 4) ? 16'h4444 : 16'(n * 16'h0101);
            dump_q.push_back(b);
        end

        hlt = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
        step();
        hlt = 1'b0; wr_en = 1'b0;
        beats = 0; done_cyc = 0; done_seen = 1'b0; hold_pending = 1'b0;
        hold_addr = '0; hold_data = '0;
        for (int k = 0; k < 200; k++) begin
            if (k == 3) begin
                check("busy_during_dump", {31'h0, busy}, 32'h1);
                wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hDEAD;
            end else begin
                wr_en = 1'b0;
            end
            dump_ready = (k % 2) == 1;
            if (dump_done) done_cyc++;
            if (hold_pending && dump_valid) begin
                check("dump_hold_addr", {28'h0, dump_addr}, {28'h0, hold_addr});
                check("dump_hold_data", {16'h0, dump_data}, {16'h0, hold_data});
            end
            hold_pending = dump_valid && !dump_ready;
            hold_addr    = dump_addr;
            hold_data    = dump_data;
            if (dump_valid && dump_ready) begin
                beats++;
                if (dump_q.size() == 0) begin
                    check("dump_extra_beat", {28'h0, dump_addr}, 32'hFFFF_FFFF);
                end else begin
                    b = dump_q.pop_front();
                    check($sformatf("dump_addr_beat%0d", beats), {28'h0, dump_addr}, {28'h0, b.addr});
                    check($sformatf("dump_data_beat%0d", beats), {16'h0, dump_data}, {16'h0, b.data});
                end
            end
            if (done_seen && !busy) break;
            if (dump_done) done_seen = 1'b1;
            step();
        end
        wr_en = 1'b0; dump_ready = 1'b0;
        check("dump_beats", beats, 15);
        check("dump_done_cycles", done_cyc, 1);
        check("dump_missing_beats", dump_q.size(), 0);
        check("dump_idle_after", {31'h0, busy}, 32'h0);

        apply_rd(1'b0, 4'd0, 16'h0, 2'b11, 4'd9, 4'd4, 16'h0909, 16'h4444, 16'h0909, 16'h4444, "post_dump_a");
        apply_rd(1'b0, 4'd0, 16'h0, 2'b11, 4'd1, 4'd15, 16'h0101, 16'h0F0F, 16'h0101, 16'h0F0F, "post_dump_b");

        // Reset while beat 6 is being presented, then restart
        dump_ready = 1'b1; hlt = 1'b1;
        step();
        hlt = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            if (dump_valid && dump_addr == 4'd6) begin
                found = 1;
                break;
            end
            step();
        end
        check("beat6_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dump_valid", {31'h0, dump_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_dump_done", {31'h0, dump_done}, 32'h0);
        check("abort_rd_data", rd_data, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_reset_idle", {31'h0, busy}, 32'h0);
        hlt = 1'b1;
        step();
        hlt = 1'b0;
        check("restart_valid", {31'h0, dump_valid}, 32'h1);
        check("restart_addr", {28'h0, dump_addr}, 32'h1);
        check("restart_data", {16'h0, dump_data}, 32'h0);
        found = 0;
        for (int k = 0; k < 60; k++) begin
            if (!busy) begin
                found = 1;
                break;
            end
            step();
        end
        check("restart_completes", found, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
